// File: rtl/miss_queue.sv
// Miss queue between the LSU cache-table lookup and the cache line manager.
// Merges same-line regular misses, drops conflict/in-progress misses, and presents entries in FIFO order.
module miss_queue #(
    parameter int DEPTH    = 4,
    parameter int ASSOC_W  = 2,
    parameter int LINE_LSB = 6
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [1:0]         IN_valid,
    input  logic [31:0]        IN_missAddr  [2],
    input  logic [31:0]        IN_writeAddr [2],
    input  logic [ASSOC_W-1:0] IN_assoc     [2],
    input  logic [2:0]         IN_mtype     [2],
    output logic [1:0]         OUT_ready,

    output logic               OUT_valid,
    output logic [31:0]        OUT_missAddr,
    output logic [31:0]        OUT_writeAddr,
    output logic [ASSOC_W-1:0] OUT_assoc,
    output logic [2:0]         OUT_mtype,
    input  logic               IN_deqReady,

    output logic [$clog2(DEPTH):0] OUT_count
);

    localparam logic [2:0] MT_REGULAR          = 3'd0;
    localparam logic [2:0] MT_REGULAR_NO_EVICT = 3'd1;
    localparam logic [2:0] MT_CONFLICT         = 3'd2;
    localparam logic [2:0] MT_TRANS_IN_PROG    = 3'd3;

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic               valid;
        logic [31:0]        miss_addr;
        logic [31:0]        write_addr;
        logic [ASSOC_W-1:0] assoc;
        logic [2:0]         mtype;
    } entry_t;

    entry_t           storage [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    logic [PTR_W:0]   free_slots;
    logic             deq;
    logic [1:0]       accept;
    logic [1:0]       hit;
    logic [1:0]       store;
    logic             same_line;
    logic [PTR_W-1:0] wr_idx1;
    logic [1:0]       n_store;
    logic [PTR_W:0]   count_next;

    function automatic logic is_regular(input logic [2:0] mt);
        return (mt == MT_REGULAR) || (mt == MT_REGULAR_NO_EVICT);
    endfunction

    function automatic logic is_dropped(input logic [2:0] mt);
        return (mt == MT_CONFLICT) || (mt == MT_TRANS_IN_PROG);
    endfunction

    always_comb begin
        free_slots = DEPTH_C - count;
        OUT_ready[0] = free_slots >= (PTR_W+1)'(1);
        OUT_ready[1] = free_slots >= (PTR_W+1)'(2);

        OUT_valid     = (count != '0);
        OUT_missAddr  = storage[rd_ptr].miss_addr;
        OUT_writeAddr = storage[rd_ptr].write_addr;
        OUT_assoc     = storage[rd_ptr].assoc;
        OUT_mtype     = storage[rd_ptr].mtype;
        OUT_count     = count;

        deq = OUT_valid && IN_deqReady;
    end

    // The head being dequeued this cycle no longer counts as a merge target.
    always_comb begin
        accept = IN_valid & OUT_ready;
        hit    = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (storage[i].valid && is_regular(storage[i].mtype) &&
                    storage[i].miss_addr[31:LINE_LSB] == IN_missAddr[p][31:LINE_LSB] &&
                    !(deq && PTR_W'(i) == rd_ptr))
                    hit[p] = 1'b1;
            end
        end

        store[0] = accept[0] && !is_dropped(IN_mtype[0]) &&
                   !(is_regular(IN_mtype[0]) && hit[0]);

        same_line = store[0] && is_regular(IN_mtype[0]) &&
                    (IN_missAddr[0][31:LINE_LSB] == IN_missAddr[1][31:LINE_LSB]);

        store[1] = accept[1] && !is_dropped(IN_mtype[1]) &&
                   !(is_regular(IN_mtype[1]) && (hit[1] || same_line));

        wr_idx1    = wr_ptr + PTR_W'(store[0]);
        n_store    = 2'(store[0]) + 2'(store[1]);
        count_next = count + (PTR_W+1)'(n_store) - (PTR_W+1)'(deq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                storage[i] <= '0;
        end else begin
            if (deq)
                storage[rd_ptr].valid <= 1'b0;
            if (store[0])
                storage[wr_ptr] <= '{valid: 1'b1, miss_addr: IN_missAddr[0],
                                     write_addr: IN_writeAddr[0], assoc: IN_assoc[0],
                                     mtype: IN_mtype[0]};
            if (store[1])
                storage[wr_idx1] <= '{valid: 1'b1, miss_addr: IN_missAddr[1],
                                      write_addr: IN_writeAddr[1], assoc: IN_assoc[1],
                                      mtype: IN_mtype[1]};
            rd_ptr <= rd_ptr + PTR_W'(deq);
            wr_ptr <= wr_ptr + PTR_W'(n_store);
            count  <= count_next;
        end
    end

endmodule

// File: tb/tb_miss_queue.sv
// Directed bench for miss_queue: vector table for single-cycle behaviour plus a wrap-around order sequence.
module tb_miss_queue;

    localparam logic [2:0] REG   = 3'd0;
    localparam logic [2:0] RNE   = 3'd1;
    localparam logic [2:0] CONF  = 3'd2;
    localparam logic [2:0] TRANS = 3'd3;
    localparam logic [2:0] INVAL = 3'd5;
    localparam logic [2:0] FLUSH = 3'd6;
    localparam logic [31:0] WOFS = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid;
    logic [31:0] in_miss  [2];
    logic [31:0] in_write [2];
    logic [1:0]  in_assoc [2];
    logic [2:0]  in_mtype [2];
    logic [1:0]  out_ready;
    logic        out_valid;
    logic [31:0] out_miss;
    logic [31:0] out_write;
    logic [1:0]  out_assoc;
    logic [2:0]  out_mtype;
    logic        deq_ready;
    logic [2:0]  out_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    miss_queue #(.DEPTH(4), .ASSOC_W(2), .LINE_LSB(6)) dut (
        .clk(clk), .rst(rst),
        .IN_valid(in_valid), .IN_missAddr(in_miss), .IN_writeAddr(in_write),
        .IN_assoc(in_assoc), .IN_mtype(in_mtype), .OUT_ready(out_ready),
        .OUT_valid(out_valid), .OUT_missAddr(out_miss), .OUT_writeAddr(out_write),
        .OUT_assoc(out_assoc), .OUT_mtype(out_mtype), .IN_deqReady(deq_ready),
        .OUT_count(out_count)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  valid;
        logic [31:0] a0;
        logic [2:0]  m0;
        logic [1:0]  as0;
        logic [31:0] a1;
        logic [2:0]  m1;
        logic [1:0]  as1;
        logic        deq;
        logic        e_valid;
        logic [31:0] e_addr;
        logic [2:0]  e_mt;
        logic [1:0]  e_assoc;
        logic [2:0]  e_count;
        logic [1:0]  e_ready;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(logic r, logic [1:0] v, logic [31:0] a0, logic [2:0] m0,
                                logic [1:0] as0, logic [31:0] a1, logic [2:0] m1, logic [1:0] as1,
                                logic d, logic ev, logic [31:0] ea, logic [2:0] em,
                                logic [1:0] eas, logic [2:0] ec, logic [1:0] er);
        vec_t x;
        x.rst = r; x.valid = v; x.a0 = a0; x.m0 = m0; x.as0 = as0;
        x.a1 = a1; x.m1 = m1; x.as1 = as1; x.deq = d;
        x.e_valid = ev; x.e_addr = ea; x.e_mt = em; x.e_assoc = eas;
        x.e_count = ec; x.e_ready = er;
        return x;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] v, input logic [31:0] a0,
                         input logic [2:0] m0, input logic [1:0] as0, input logic [31:0] a1,
                         input logic [2:0] m1, input logic [1:0] as1, input logic d);
        rst = r; in_valid = v;
        in_miss[0] = a0; in_write[0] = a0 + WOFS; in_mtype[0] = m0; in_assoc[0] = as0;
        in_miss[1] = a1; in_write[1] = a1 + WOFS; in_mtype[1] = m1; in_assoc[1] = as1;
        deq_ready = d;
    endtask

    task automatic check_state(input int idx, input logic ev, input logic [31:0] ea,
                               input logic [2:0] em, input logic [1:0] eas,
                               input logic [2:0] ec, input logic [1:0] er);
        check("valid", idx, 32'(out_valid), 32'(ev));
        check("count", idx, 32'(out_count), 32'(ec));
        check("ready", idx, 32'(out_ready), 32'(er));
        if (ev) begin
            check("miss_addr", idx, out_miss, ea);
            check("write_addr", idx, out_write, ea + WOFS);
            check("mtype", idx, 32'(out_mtype), 32'(em));
            check("assoc", idx, 32'(out_assoc), 32'(eas));
        end
    endtask

    function automatic logic [31:0] wa(int k);
        return 32'h9000_0000 + 32'(k) * 32'h40;
    endfunction

    initial begin
        //            rst v    a0            m0    as a1            m1    as d  ev ea            em    eas cnt rdy
        vecs.push_back(mk(1, 2'b00, 0,            REG,  0, 0,            REG,  0, 0, 0, 0,            REG,  0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b01, 32'h8000_1040, REG,  0, 0,            REG,  0, 0, 1, 32'h8000_1040, REG,  0, 1, 2'b11));
        vecs.push_back(mk(0, 2'b00, 0,            REG,  0, 0,            REG,  0, 1, 0, 0,            REG,  0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b11, 32'h8000_1040, REG,  0, 32'h8000_1044, REG,  0, 0, 1, 32'h8000_1040, REG,  0, 1, 2'b11));
        vecs.push_back(mk(0, 2'b01, 32'h8000_2000, REG,  0, 0,            REG,  0, 0, 1, 32'h8000_1040, REG,  0, 2, 2'b11));
        vecs.push_back(mk(0, 2'b11, 32'h8000_3000, REG,  0, 32'h8000_4000, REG,  0, 0, 1, 32'h8000_1040, REG,  0, 4, 2'b00));
        vecs.push_back(mk(0, 2'b01, 32'h8000_5000, REG,  0, 0,            REG,  0, 0, 1, 32'h8000_1040, REG,  0, 4, 2'b00));
        vecs.push_back(mk(0, 2'b01, 32'h8000_5000, REG,  0, 0,            REG,  0, 1, 1, 32'h8000_2000, REG,  0, 3, 2'b01));
        vecs.push_back(mk(0, 2'b01, 32'h8000_2010, REG,  0, 0,            REG,  0, 0, 1, 32'h8000_2000, REG,  0, 3, 2'b01));
        vecs.push_back(mk(0, 2'b01, 32'h8000_2020, REG,  0, 0,            REG,  0, 1, 1, 32'h8000_3000, REG,  0, 3, 2'b01));
        vecs.push_back(mk(0, 2'b00, 0,            REG,  0, 0,            REG,  0, 1, 1, 32'h8000_4000, REG,  0, 2, 2'b11));
        vecs.push_back(mk(0, 2'b00, 0,            REG,  0, 0,            REG,  0, 1, 1, 32'h8000_2020, REG,  0, 1, 2'b11));
        vecs.push_back(mk(0, 2'b00, 0,            REG,  0, 0,            REG,  0, 1, 0, 0,            REG,  0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b11, 32'h8000_1000, CONF, 0, 32'h8000_1000, TRANS, 0, 0, 0, 0,           REG,  0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b11, 32'h8000_7000, FLUSH,1, 32'h8000_7000, FLUSH, 2, 0, 1, 32'h8000_7000, FLUSH,1, 2, 2'b11));
        vecs.push_back(mk(0, 2'b00, 0,            REG,  0, 0,            REG,  0, 1, 1, 32'h8000_7000, FLUSH,2, 1, 2'b11));
        vecs.push_back(mk(0, 2'b00, 0,            REG,  0, 0,            REG,  0, 1, 0, 0,            REG,  0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b11, 32'h8000_8000, INVAL,3, 32'h8000_8004, REG,  1, 0, 1, 32'h8000_8000, INVAL,3, 2, 2'b11));
        vecs.push_back(mk(0, 2'b00, 0,            REG,  0, 0,            REG,  0, 1, 1, 32'h8000_8004, REG,  1, 1, 2'b11));
        vecs.push_back(mk(0, 2'b11, 32'h8000_9000, REG,  0, 32'h8000_A000, REG,  0, 0, 1, 32'h8000_8004, REG,  1, 3, 2'b01));
        vecs.push_back(mk(1, 2'b11, 32'h8000_B000, REG,  0, 32'h8000_C000, REG,  0, 1, 0, 0,            REG,  0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b01, 32'h8000_B000, REG,  2, 0,            REG,  0, 0, 1, 32'h8000_B000, REG,  2, 1, 2'b11));
        vecs.push_back(mk(0, 2'b00, 0,            REG,  0, 0,            REG,  0, 1, 0, 0,            REG,  0, 0, 2'b11));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].a0, vecs[i].m0, vecs[i].as0,
                  vecs[i].a1, vecs[i].m1, vecs[i].as1, vecs[i].deq);
            @(posedge clk);
            @(negedge clk);
            check_state(i, vecs[i].e_valid, vecs[i].e_addr, vecs[i].e_mt, vecs[i].e_assoc,
                        vecs[i].e_count, vecs[i].e_ready);
        end

        // Two entries in flight, one in and one out per cycle, pointers wrap twice.
        drive(0, 2'b11, wa(0), RNE, 0, wa(1), RNE, 1, 0);
        @(posedge clk);
        @(negedge clk);
        check_state(100, 1, wa(0), RNE, 0, 2, 2'b11);
        for (int k = 1; k <= 10; k++) begin
            drive(0, 2'b01, wa(k + 1), RNE, 2'(k + 1), 0, REG, 0, 1);
            @(posedge clk);
            @(negedge clk);
            check_state(100 + k, 1, wa(k), RNE, 2'(k), 2, 2'b11);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
